// File: rtl/fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO: wrap-aware pointer increment and count width.
// Pure functions, no latency and no flow control of their own.
package fifo_pkg;

  // Pointers wrap explicitly from depth-1 to 0 so non-power-of-two depths use every entry.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram_sync_mem.sv
// FIFO storage: one synchronous write port, read port combinational or registered (FIFO_RAM_SYNC_REG_OUT_EN).
// Read latency 0 (combinational) or 1 edge (registered, rd_en gated); no flow control of its own.
module fifo_ram_sync_mem #(
  parameter int Depth = 16,
  parameter int Width = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]         wr_dat,
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
  input  logic                     rd_en,
`endif
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [Width-1:0]         rd_dat
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

`ifdef FIFO_RAM_SYNC_REG_OUT_EN
  logic [Width-1:0] rd_dat_d;
  logic [Width-1:0] rd_dat_q;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem_q[rd_addr];
    end
  end

  // Data register is left unreset so it maps onto the block-RAM output register.
  always_ff @(posedge clk) begin
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;
`else
  assign rd_dat = mem_q[rd_addr];
`endif

endmodule

// File: rtl/fifo_ram_sync_flex.sv
// Any-depth synchronous valid/ready FIFO with count, almost flags and flush; FIFO_RAM_SYNC_REG_OUT_EN adds a prefetch register.
// Write-to-read latency 1 cycle (2 with prefetch); write_ready drops only at count == Depth, read_valid only when empty.
module fifo_ram_sync_flex
  import fifo_pkg::*;
#(
  parameter int Depth     = 16,
  parameter int Width     = 32,
  parameter int AFullThr  = Depth - 1,
  parameter int AEmptyThr = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          write_valid,
  input  logic [Width-1:0]              write_data,
  output logic                          write_ready,
  output logic                          read_valid,
  output logic [Width-1:0]              read_data,
  input  logic                          read_ready,
  output logic [cnt_width(Depth)-1:0]   count,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = cnt_width(Depth);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [CntW-1:0] AFull   = CntW'(AFullThr);
  localparam logic [CntW-1:0] AEmpty  = CntW'(AEmptyThr);

  if (Depth < 2) begin : g_bad_depth
    $error("fifo_ram_sync_flex: Depth must be >= 2");
  end
  if (AFullThr > Depth) begin : g_bad_afull
    $error("fifo_ram_sync_flex: AFullThr must be <= Depth");
  end
  if (AEmptyThr >= Depth) begin : g_bad_aempty
    $error("fifo_ram_sync_flex: AEmptyThr must be < Depth");
  end

  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            wr_fire, rd_fire;

`ifdef FIFO_RAM_SYNC_REG_OUT_EN
  logic            out_vld_d, out_vld_q;
  logic            ram_ld;
  logic [CntW-1:0] ram_cnt;

  // count covers the output register too, so the RAM holds count minus that entry.
  assign ram_cnt    = count_q - CntW'(out_vld_q);
  assign read_valid = out_vld_q;
`else
  assign read_valid = (count_q != '0);
`endif

  assign write_ready  = (count_q != CntFull);
  assign wr_fire      = write_valid && write_ready;
  assign rd_fire      = read_valid && read_ready;
  assign count        = count_q;
  assign almost_full  = (count_q >= AFull);
  assign almost_empty = (count_q <= AEmpty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
    out_vld_d = out_vld_q;
    ram_ld    = 1'b0;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
      out_vld_d = 1'b0;
`endif
    end else begin
      if (wr_fire) begin
        wr_ptr_d = PtrW'(ptr_inc(int'(wr_ptr_q), Depth));
      end
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
      // Refill the output register whenever it is empty or being consumed this edge.
      ram_ld = (ram_cnt != '0) && (!out_vld_q || rd_fire);
      if (ram_ld) begin
        rd_ptr_d  = PtrW'(ptr_inc(int'(rd_ptr_q), Depth));
        out_vld_d = 1'b1;
      end else if (rd_fire) begin
        out_vld_d = 1'b0;
      end
`else
      if (rd_fire) begin
        rd_ptr_d = PtrW'(ptr_inc(int'(rd_ptr_q), Depth));
      end
`endif
      if (wr_fire && !rd_fire) begin
        count_d = count_q + CntW'(1);
      end else if (rd_fire && !wr_fire) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
      out_vld_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
      out_vld_q <= out_vld_d;
`endif
    end
  end

  fifo_ram_sync_mem #(
    .Depth (Depth),
    .Width (Width)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire && !flush),
    .wr_addr (wr_ptr_q),
    .wr_dat  (write_data),
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
    .rd_en   (ram_ld),
`endif
    .rd_addr (rd_ptr_q),
    .rd_dat  (read_data)
  );

endmodule

// File: tb/tb_fifo_ram_sync_flex.sv
// Directed and random checks of fifo_ram_sync_flex (Depth=6, Width=8) against a queue-based reference model.
module tb_fifo_ram_sync_flex;

  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int AFT   = 5;
  localparam int AET   = 1;
`ifdef FIFO_RAM_SYNC_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             write_valid;
  logic [WIDTH-1:0] write_data;
  logic             write_ready;
  logic             read_valid;
  logic [WIDTH-1:0] read_data;
  logic             read_ready;
  logic [2:0]       count;
  logic             almost_full;
  logic             almost_empty;

  fifo_ram_sync_flex #(
    .Depth     (DEPTH),
    .Width     (WIDTH),
    .AFullThr  (AFT),
    .AEmptyThr (AET)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .write_valid  (write_valid),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .read_valid   (read_valid),
    .read_data    (read_data),
    .read_ready   (read_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored words in order, each tagged with the edge index that wrote it.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               e;
  } ent_t;

  ent_t q[$];
  int   edge_n   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A word becomes visible LAT-1 cycles after the cycle following its write edge.
  function automatic bit model_rv();
    return (q.size() > 0) && (edge_n >= q[0].e + LAT - 1);
  endfunction

  task automatic check_outputs(input string ph);
    int n;
    n = q.size();
    chk({ph, "/count"},        32'(count),        32'(n));
    chk({ph, "/write_ready"},  32'(write_ready),  32'(n != DEPTH));
    chk({ph, "/almost_full"},  32'(almost_full),  32'(n >= AFT));
    chk({ph, "/almost_empty"}, 32'(almost_empty), 32'(n <= AET));
    chk({ph, "/read_valid"},   32'(read_valid),   32'(model_rv()));
    if (model_rv()) begin
      chk({ph, "/read_data"}, 32'(read_data), 32'(q[0].d));
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then apply the transfer rules to the model.
  task automatic cyc(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic fl);
    bit wr, rd;
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
    flush       = fl;
    #1;
    check_outputs("cyc");
    wr = wv && (q.size() != DEPTH);
    rd = rr && model_rv();
    @(posedge clk);
    edge_n++;
    if (fl) begin
      q.delete();
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back('{d: wd, e: edge_n});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string ph);
    chk({ph, "/count"},        32'(count),        0);
    chk({ph, "/write_ready"},  32'(write_ready),  1);
    chk({ph, "/read_valid"},   32'(read_valid),   0);
    chk({ph, "/almost_full"},  32'(almost_full),  0);
    chk({ph, "/almost_empty"}, 32'(almost_empty), 1);
  endtask

  initial begin
    rstn        = 1'b0;
    flush       = 1'b0;
    write_valid = 1'b0;
    write_data  = '0;
    read_ready  = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Fill to Depth, then one more write that must be refused.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("full_count", 32'(count), 6);
    chk("full_write_ready", 32'(write_ready), 0);
    chk("full_almost_full", 32'(almost_full), 1);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("seventh_write_count", 32'(count), 6);

    // Drain: 0x10..0x15 in order, then empty.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(read_valid), 1);
      chk("drain_data", 32'(read_data), 32'(8'h10 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained_read_valid", 32'(read_valid), 0);
    chk("drained_count", 32'(count), 0);
    chk("drained_almost_empty", 32'(almost_empty), 1);

    // At full, simultaneous read and write: only the read fires.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_rw_count", 32'(count), 5);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous streaming across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      if (i >= LAT) chk("stream_no_gap", 32'(read_valid), 1);
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk("stream_count_bound", 32'(int'(count) <= LAT), 1);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count=3 with a concurrent write.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("preflush_count", 32'(count), 3);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_read_valid", 32'(read_valid), 0);
    cyc(1'b1, 8'h60, 1'b0, 1'b0);
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges at count=4.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    chk("prereset_count", 32'(count), 4);
    write_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_reset_values("async_reset");
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 1; i < LAT; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_reset_valid", 32'(read_valid), 1);
    chk("post_reset_data", 32'(read_data), 32'hAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          8'($urandom),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ram_sync_flex.md
# fifo_ram_sync_flex

Parametrised synchronous RAM-backed FIFO, the general-purpose successor for buffering valid/ready streams inside one clock domain. Supports any depth ≥ 2, not just powers of two, and uses all Depth entries. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and an optional registered read port for block-RAM inference.

## Interface
- Depth, 16: number of storage entries; any integer ≥ 2.
- Width, 32: data width in bits.
- AFullThr, Depth-1: almost_full asserts when count ≥ AFullThr.
- AEmptyThr, 1: almost_empty asserts when count ≤ AEmptyThr.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- write_valid  in  1  producer offers write_data.
- write_data  in  Width  data to enqueue.
- write_ready  out  1  FIFO can accept a word.
- read_valid  out  1  read_data holds the head entry.
- read_data  out  Width  head entry.
- read_ready  in  1  consumer accepts the head entry.
- count  out  $clog2(Depth+1)  number of stored entries.
- almost_full  out  1  count ≥ AFullThr.
- almost_empty  out  1  count ≤ AEmptyThr.

## Operation
- Write fires when write_valid && write_ready. Read fires when read_valid && read_ready.
- write_ready = (count != Depth). It does not depend on write_valid or read_ready, so there is no combinational input-to-ready path.
- read_valid = (a head entry is presented). read_data is don't-care while read_valid = 0.
- Pointers are $clog2(Depth) bits wide and wrap explicitly from Depth-1 to 0. Wrapping by arithmetic overflow is not used.
- count is a registered value: +1 on write only, -1 on read only, unchanged when both or neither fire. It ranges 0..Depth.
- Simultaneous read and write are allowed at any fill level except full, where write_ready = 0 and no write can fire.
- flush takes priority over both read and write. It zeroes the pointers and count. A write in the flush cycle is dropped; a read in the flush cycle is discarded.
- RAM contents are not reset; only control state is.
- Reset values: count = 0, write_ready = 1, read_valid = 0, almost_full = (AFullThr == 0), almost_empty = 1.
- Elaboration-time assertions: Depth ≥ 2, AFullThr ≤ Depth, AEmptyThr < Depth.

## Timing
- Write-to-read latency (combinational-read mode): a word written at edge N is visible on read_data with read_valid = 1 after edge N, i.e. in cycle N+1.
- read_data in this mode is a combinational RAM read at the read pointer.
- A read at edge N presents the next entry in cycle N+1, so back-to-back reads give one word per cycle.
- Flags are combinational decodes of the registered count, so they change in the cycle after the causing transfer.
- When rstn is asserted mid-transfer, all control state clears immediately. Any in-flight word is lost.

## Configuration
- FIFO_RAM_SYNC_REG_OUT_EN defined: the RAM read is synchronous and feeds a one-entry output register (prefetch stage).
  - Write-to-read_valid latency becomes 2 cycles when empty.
  - Throughput stays one word per cycle.
  - count includes the output-register entry, so total capacity remains Depth.
  - read_data is driven directly from a flop.
- FIFO_RAM_SYNC_REG_OUT_EN undefined: combinational-read behaviour as described in Operation and Timing.

## Structure
- Package fifo_pkg holds:
  - function ptr_inc(ptr, depth), the wrap-aware increment;
  - function cnt_width(depth), which returns $clog2(depth+1).
- Sub-module fifo_ram_sync_mem holds the storage:
  - parameters Depth and Width;
  - one synchronous write port;
  - a read port that is combinational or registered depending on FIFO_RAM_SYNC_REG_OUT_EN.
- Pointer, count, flag and prefetch control live in the top module.

## Test plan
- Depth=6, Width=8: write 0x10..0x15 with read_ready=0 -> count reaches 6, write_ready=0, almost_full=1. A seventh write is not accepted.
- Depth=6: drain the full FIFO -> read_data sequence is 0x10..0x15, then read_valid=0, count=0, almost_empty=1.
- Depth=6: stream 20 words with write_valid=read_ready=1 continuously -> data arrives in order with no gaps after the initial latency, pointers wrap past index 5 correctly, and count stays 0 or 1.
- Depth=6 at count=6: assert read_ready and write_valid together -> the read fires, the write does not, and count becomes 5.
- At count=3: pulse flush together with write_valid -> count=0 and read_valid=0 next cycle. The written word never appears at read_data.
- At count=4: assert rstn=0 asynchronously between edges -> outputs take their reset values immediately. Then write 0xAA -> read_data=0xAA after 1 cycle (or 2 cycles with FIFO_RAM_SYNC_REG_OUT_EN).
